// File: rtl/div_unit.sv
// Multi-cycle unsigned restoring divider for the Execute stage.
// Stalls the pipeline while iterating and pulses DoneE for one cycle with the result.
module div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             StartE,
    input  logic [WIDTH-1:0] SrcAE,
    input  logic [WIDTH-1:0] SrcBE,
    input  logic             FlushE,
    output logic             BusyE,
    output logic             DoneE,
    output logic [WIDTH-1:0] QuotientE,
    output logic [WIDTH-1:0] RemainderE,
    output logic [3:0]       DivFlagsE
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           r_state;
    state_t           w_next;
    logic [5:0]       r_cnt;
    logic [WIDTH-1:0] r_dvd;
    logic [WIDTH-1:0] r_dvs;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quot;
    logic [WIDTH-1:0] r_remo;

    logic             w_start;
    logic             w_zero;
    logic             w_last;
    logic             w_ge;
    logic [WIDTH:0]   w_cand;
    logic [WIDTH:0]   w_diff;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [WIDTH-1:0] w_quo_nxt;

    assign w_start = (r_state == IDLE) & StartE & ~FlushE;
    assign w_zero  = (SrcBE == '0);
    assign w_last  = (r_cnt == 6'(WIDTH - 1));

    // One restoring step: a set candidate MSB means it already exceeds any divisor,
    // otherwise the MSB of the WIDTH+1-bit difference is the borrow.
    assign w_cand    = {r_rem, r_dvd[WIDTH-1]};
    assign w_diff    = w_cand - {1'b0, r_dvs};
    assign w_ge      = w_cand[WIDTH] | ~w_diff[WIDTH];
    assign w_rem_nxt = w_ge ? w_diff[WIDTH-1:0] : w_cand[WIDTH-1:0];
    assign w_quo_nxt = {r_dvd[WIDTH-2:0], w_ge};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        BusyE  = 1'b0;
        DoneE  = 1'b0;
        case (r_state)
            IDLE: begin
                BusyE = w_start;
                if (w_start) begin
                    w_next = w_zero ? DONE : RUN;
                end
            end
            RUN: begin
                BusyE = 1'b1;
                if (FlushE) begin
                    w_next = IDLE;
                end else if (w_last) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                DoneE  = 1'b1;
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Working registers are always reloaded on start, so they need no reset.
    always_ff @(posedge clk) begin
        if (w_start) begin
            r_dvd <= SrcAE;
            r_dvs <= SrcBE;
            r_rem <= '0;
        end else if (r_state == RUN) begin
            r_dvd <= w_quo_nxt;
            r_rem <= w_rem_nxt;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_cnt  <= '0;
            r_quot <= '0;
            r_remo <= '0;
        end else begin
            if (w_start) begin
                r_cnt <= '0;
            end else if (r_state == RUN) begin
                r_cnt <= r_cnt + 6'd1;
            end

            if (w_start & w_zero) begin
                r_quot <= '1;
                r_remo <= SrcAE;
            end else if ((r_state == RUN) & ~FlushE & w_last) begin
                r_quot <= w_quo_nxt;
                r_remo <= w_rem_nxt;
            end
        end
    end

    assign QuotientE  = r_quot;
    assign RemainderE = r_remo;
    assign DivFlagsE  = {r_quot[WIDTH-1], (r_quot == '0), 2'b00};

endmodule
